demux16_buf: RTL and testbench
==============================

DEMUX16_BUF -- requirements
Module: demux16_buf

Interface
REQ-001 Parameter: WIDTH, default 4, data bit width (n) of every channel; legal range 1..64.
REQ-002 The block SHALL have one clock and an asynchronous active-low reset, with ports as listed below.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 in_valid  input  1  upstream word present.
REQ-006 in_ready  output  1  block accepts word this cycle; combinational.
REQ-007 in_sel  input  4  destination channel index, 0..15.
REQ-008 in_data  input  WIDTH  data word.
REQ-009 out_valid  output  16  bit k = channel k holds a word.
REQ-010 out_ready  input  16  bit k = downstream consumer k takes the word.
REQ-011 out_data  output  16*WIDTH  channel k occupies bits [(k+1)*WIDTH-1 : k*WIDTH].
REQ-012 acc_cnt  output  16  count of accepted words.

Function
REQ-013 Each channel SHALL contain one WIDTH-bit holding register and one full flag; out_valid[k] = full[k].
REQ-014 in_ready SHALL equal !full[in_sel] || out_ready[in_sel] (pass-through drain); no dependence on in_valid.
REQ-015 Accept SHALL occur when in_valid && in_ready; on the next edge channel in_sel loads in_data and sets full.
REQ-016 Latency SHALL be 1 cycle: a word accepted at edge N appears on out_data/out_valid after edge N.
REQ-017 Drain SHALL occur for channel k when out_valid[k] && out_ready[k]; full[k] clears on that edge unless channel k is loaded on the same edge.
REQ-018 Simultaneous drain and load of the same channel SHALL leave full=1 with the new word; the old word counts as delivered.
REQ-019 Channels other than in_sel SHALL be unaffected by an accept; any subset of channels MAY drain in the same cycle.
REQ-020 A channel's data register SHALL hold its last loaded value while not full; it changes only on load.
REQ-021 in_valid with full[in_sel]=1 and out_ready[in_sel]=0 SHALL stall (in_ready=0); no word is dropped or overwritten.
REQ-022 in_sel and in_data SHALL be sampled only on an accept edge; changes while stalled are legal and take effect immediately in in_ready.
REQ-023 acc_cnt SHALL increment by 1 on every accept edge and wrap from 0xFFFF to 0x0000.
REQ-024 out_ready bits for empty channels SHALL be ignored.
REQ-025 Words to one channel SHALL be delivered in acceptance order; there is no ordering between channels.

Reset
REQ-026 With rst_n low, the block SHALL immediately force out_valid=0, out_data=0 and acc_cnt=0, independent of clk.
REQ-027 During reset, in_ready SHALL follow REQ-014 with full=0, i.e. 1, but no accept SHALL take effect.
REQ-028 Reset asserted mid-operation SHALL discard all held words; the first accept after rst_n rises SHALL behave as from a clean state.

Verification
REQ-029 Reset then in_valid=1, in_sel=5, in_data=0xA for 1 cycle -> next cycle out_valid=0x0020, channel 5 data=0xA, acc_cnt=1.
REQ-030 Channel 3 full, out_ready[3]=0, in_sel=3, in_valid=1 -> in_ready=0 for all stall cycles; channel 3 data unchanged; acc_cnt unchanged.
REQ-031 Channel 3 full with 0x1, out_ready[3]=1, in_sel=3, in_data=0x2 -> in_ready=1; next cycle out_valid[3]=1, data=0x2, acc_cnt+1.
REQ-032 All 16 channels loaded with in_data=k on cycles 0..15, out_ready=0 -> out_valid=0xFFFF, each channel k=k; then out_ready=0xFFFF for 1 cycle -> out_valid=0x0000.
REQ-033 0xFFFF accepts after reset then 1 more -> acc_cnt reads 0xFFFF then 0x0000.
REQ-034 rst_n pulsed low between clock edges with 4 channels full -> out_valid=0 and acc_cnt=0 before the next edge.

Source files
------------

// File: rtl/demux16_buf.sv
// demux16_buf: 1-to-16 demultiplexer with a one-word holding register per channel.
// An upstream word is steered to channel in_sel; each channel drains independently.
module demux16_buf #(
  parameter int WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [3:0]            in_sel,
  input  logic [WIDTH-1:0]      in_data,
  output logic [15:0]           out_valid,
  input  logic [15:0]           out_ready,
  output logic [16*WIDTH-1:0]   out_data,
  output logic [15:0]           acc_cnt
);

  logic [15:0]          r_full;
  logic [16*WIDTH-1:0]  r_data;
  logic [15:0]          r_acc_cnt;
  logic                 w_accept;
  logic [15:0]          w_load;
  logic [15:0]          w_drain;

  // A full channel can still take a word when its consumer drains on the same edge.
  assign in_ready = !r_full[in_sel] || out_ready[in_sel];
  assign w_accept = in_valid && in_ready;
  assign w_drain  = r_full & out_ready;

  // One-hot load strobe for the selected channel on an accept.
  always_comb begin
    w_load = 16'd0;
    if (w_accept) begin
      w_load[in_sel] = 1'b1;
    end else begin
      w_load = 16'd0;
    end
  end

  // Full flags: load wins over drain, so a simultaneous drain+load stays full.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_full <= 16'd0;
    end else begin
      r_full <= (r_full & ~w_drain) | w_load;
    end
  end

  // Per-channel data registers change only on load and keep stale data when empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data <= {(16*WIDTH){1'b0}};
    end else begin
      for (int k = 0; k < 16; k++) begin
        if (w_load[k]) begin
          r_data[k*WIDTH +: WIDTH] <= in_data;
        end else begin
          r_data[k*WIDTH +: WIDTH] <= r_data[k*WIDTH +: WIDTH];
        end
      end
    end
  end

  // Accepted-word counter, wraps naturally at 16 bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc_cnt <= 16'd0;
    end else if (w_accept) begin
      r_acc_cnt <= r_acc_cnt + 16'd1;
    end else begin
      r_acc_cnt <= r_acc_cnt;
    end
  end

  assign out_valid = r_full;
  assign out_data  = r_data;
  assign acc_cnt   = r_acc_cnt;

endmodule

// File: tb/tb_demux16_buf.sv
// Directed self-checking bench for demux16_buf (WIDTH=4).
// Inputs change 2 time units after a rising edge; outputs are sampled there too.
module tb_demux16_buf;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_sel;
  logic [3:0]  in_data;
  logic [15:0] out_valid;
  logic [15:0] out_ready;
  logic [63:0] out_data;
  logic [15:0] acc_cnt;

  int errors = 0;
  int checks = 0;

  demux16_buf #(.WIDTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_sel(in_sel), .in_data(in_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .acc_cnt(acc_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [3:0] chan(input int k);
    return out_data[k*4 +: 4];
  endfunction

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b1; in_sel = 4'd5; in_data = 4'hA; out_ready = 16'h0000;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    repeat (2) @(posedge clk);
    #2;
    checks++; if (out_valid !== 16'h0000) begin errors++; $display("FAIL reset_out_valid: got %h expected 0000", out_valid); end
    checks++; if (acc_cnt !== 16'h0000) begin errors++; $display("FAIL reset_acc_cnt: got %h expected 0000", acc_cnt); end
    checks++; if (out_data !== 64'h0) begin errors++; $display("FAIL reset_out_data: got %h expected 0", out_data); end
    in_valid = 1'b0;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single();
    in_valid = 1'b1; in_sel = 4'd5; in_data = 4'hA;
    tick();
    in_valid = 1'b0;
    checks++; if (out_valid !== 16'h0020) begin errors++; $display("FAIL single_valid: got %h expected 0020", out_valid); end
    checks++; if (chan(5) !== 4'hA) begin errors++; $display("FAIL single_data: got %h expected a", chan(5)); end
    checks++; if (acc_cnt !== 16'd1) begin errors++; $display("FAIL single_cnt: got %h expected 0001", acc_cnt); end
    out_ready = 16'h0020;
    tick();
    out_ready = 16'h0000;
    checks++; if (out_valid !== 16'h0000) begin errors++; $display("FAIL single_drain: got %h expected 0000", out_valid); end
    checks++; if (chan(5) !== 4'hA) begin errors++; $display("FAIL single_hold: got %h expected a", chan(5)); end
  endtask

  task automatic test_stall();
    in_valid = 1'b1; in_sel = 4'd3; in_data = 4'h7;
    tick();
    in_data = 4'hC; out_ready = 16'h0004;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_ready[%0d]: got %b expected 0", i, in_ready); end
      tick();
      checks++; if (chan(3) !== 4'h7) begin errors++; $display("FAIL stall_data[%0d]: got %h expected 7", i, chan(3)); end
      checks++; if (acc_cnt !== 16'd2) begin errors++; $display("FAIL stall_cnt[%0d]: got %h expected 0002", i, acc_cnt); end
      checks++; if (out_valid !== 16'h0008) begin errors++; $display("FAIL stall_valid[%0d]: got %h expected 0008", i, out_valid); end
    end
    in_valid = 1'b0; out_ready = 16'h0000;
    in_sel = 4'd4;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stall_resel_ready: got %b expected 1", in_ready); end
    in_sel = 4'd3;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_back_ready: got %b expected 0", in_ready); end
  endtask

  task automatic test_pass_through();
    in_valid = 1'b1; in_sel = 4'd3; in_data = 4'h1; out_ready = 16'h0008;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL pass_ready: got %b expected 1", in_ready); end
    tick();
    checks++; if (out_valid !== 16'h0008) begin errors++; $display("FAIL pass_valid1: got %h expected 0008", out_valid); end
    checks++; if (chan(3) !== 4'h1) begin errors++; $display("FAIL pass_data1: got %h expected 1", chan(3)); end
    in_data = 4'h2;
    tick();
    in_valid = 1'b0;
    checks++; if (out_valid !== 16'h0008) begin errors++; $display("FAIL pass_valid2: got %h expected 0008", out_valid); end
    checks++; if (chan(3) !== 4'h2) begin errors++; $display("FAIL pass_data2: got %h expected 2", chan(3)); end
    checks++; if (acc_cnt !== 16'd4) begin errors++; $display("FAIL pass_cnt: got %h expected 0004", acc_cnt); end
    tick();
    out_ready = 16'h0000;
    checks++; if (out_valid !== 16'h0000) begin errors++; $display("FAIL pass_drain: got %h expected 0000", out_valid); end
  endtask

  task automatic test_subset_drain();
    logic [3:0] sels [3];
    sels[0] = 4'd1; sels[1] = 4'd2; sels[2] = 4'd9;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_sel = sels[i]; in_data = sels[i];
      tick();
    end
    checks++; if (out_valid !== 16'h0206) begin errors++; $display("FAIL subset_fill: got %h expected 0206", out_valid); end
    in_sel = 4'd0; in_data = 4'hF; out_ready = 16'h0006;
    tick();
    in_valid = 1'b0; out_ready = 16'h0000;
    checks++; if (out_valid !== 16'h0201) begin errors++; $display("FAIL subset_drain: got %h expected 0201", out_valid); end
    checks++; if (chan(9) !== 4'h9) begin errors++; $display("FAIL subset_ch9: got %h expected 9", chan(9)); end
    checks++; if (chan(0) !== 4'hF) begin errors++; $display("FAIL subset_ch0: got %h expected f", chan(0)); end
    checks++; if (acc_cnt !== 16'd8) begin errors++; $display("FAIL subset_cnt: got %h expected 0008", acc_cnt); end
    out_ready = 16'hFFFF;
    tick();
    out_ready = 16'h0000;
    checks++; if (out_valid !== 16'h0000) begin errors++; $display("FAIL subset_clear: got %h expected 0000", out_valid); end
  endtask

  task automatic test_fill_drain();
    for (int k = 0; k < 16; k++) begin
      in_valid = 1'b1; in_sel = 4'(k); in_data = 4'(k);
      tick();
    end
    in_valid = 1'b0;
    checks++; if (out_valid !== 16'hFFFF) begin errors++; $display("FAIL fill_valid: got %h expected ffff", out_valid); end
    checks++; if (out_data !== 64'hFEDCBA9876543210) begin errors++; $display("FAIL fill_data: got %h expected fedcba9876543210", out_data); end
    checks++; if (acc_cnt !== 16'd24) begin errors++; $display("FAIL fill_cnt: got %h expected 0018", acc_cnt); end
    out_ready = 16'hFFFF;
    tick();
    out_ready = 16'h0000;
    checks++; if (out_valid !== 16'h0000) begin errors++; $display("FAIL fill_drain: got %h expected 0000", out_valid); end
  endtask

  task automatic test_async_reset();
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1; in_sel = 4'(k); in_data = 4'(k + 4);
      tick();
    end
    in_valid = 1'b0;
    checks++; if (out_valid !== 16'h000F) begin errors++; $display("FAIL areset_pre: got %h expected 000f", out_valid); end
    #1;
    rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 16'h0000) begin errors++; $display("FAIL areset_valid: got %h expected 0000", out_valid); end
    checks++; if (acc_cnt !== 16'h0000) begin errors++; $display("FAIL areset_cnt: got %h expected 0000", acc_cnt); end
    checks++; if (out_data !== 64'h0) begin errors++; $display("FAIL areset_data: got %h expected 0", out_data); end
    tick();
    rst_n = 1'b1;
    in_valid = 1'b1; in_sel = 4'd7; in_data = 4'h3;
    tick();
    in_valid = 1'b0;
    checks++; if (out_valid !== 16'h0080) begin errors++; $display("FAIL areset_post_valid: got %h expected 0080", out_valid); end
    checks++; if (acc_cnt !== 16'd1) begin errors++; $display("FAIL areset_post_cnt: got %h expected 0001", acc_cnt); end
  endtask

  task automatic test_wrap();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    in_valid = 1'b1; in_sel = 4'd0; in_data = 4'h6; out_ready = 16'hFFFF;
    repeat (65535) @(posedge clk);
    #2;
    checks++; if (acc_cnt !== 16'hFFFF) begin errors++; $display("FAIL wrap_max: got %h expected ffff", acc_cnt); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL wrap_ready: got %b expected 1", in_ready); end
    tick();
    in_valid = 1'b0;
    checks++; if (acc_cnt !== 16'h0000) begin errors++; $display("FAIL wrap_zero: got %h expected 0000", acc_cnt); end
    checks++; if (out_valid !== 16'h0001) begin errors++; $display("FAIL wrap_valid: got %h expected 0001", out_valid); end
    out_ready = 16'h0000;
  endtask

  initial begin
    test_reset();
    test_single();
    test_stall();
    test_pass_through();
    test_subset_drain();
    test_fill_drain();
    test_async_reset();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
